// File: rtl/mul_unit.sv
// Sequential shift-add multiplier for mul/mulh/mulhsu/mulhu with a valid/ready handshake.
// Define MUL_EARLY_OUT_EN to leave BUSY as soon as the remaining multiplier magnitude is zero.
module mul_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   ALUSel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] MulRes
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic             op_ok_q;
  logic             neg_q;
  logic [2*N-1:0]   mcand_q;
  logic [2*N-1:0]   acc_q;
  logic [N-1:0]     mplier_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             last_step;
  logic             a_neg, b_neg;
  logic [N-1:0]     a_mag, b_mag;
  logic [2*N-1:0]   acc_step;
  logic [2*N-1:0]   prod;
  logic [N-1:0]     res_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  // A is signed for mul/mulh/mulhsu, B only for mul/mulh. The negated most
  // negative value reads back as 2^(N-1), which is the correct unsigned magnitude.
  always_comb begin
    a_neg = (ALUSel[1:0] != 2'b11) & A[N-1];
    b_neg = ~ALUSel[1] & B[N-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
  end

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod     = neg_q ? -acc_step : acc_step;
    if (!op_ok_q)          res_d = '0;
    else if (op_q == 2'b00) res_d = prod[N-1:0];
    else                    res_d = prod[2*N-1:N];
`ifdef MUL_EARLY_OUT_EN
    last_step = (cnt_q == CW'(N - 1)) || ((mplier_q >> 1) == '0);
`else
    last_step = (cnt_q == CW'(N - 1));
`endif
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      op_ok_q  <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      MulRes   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q     <= ALUSel[1:0];
          op_ok_q  <= (ALUSel[3:2] == 2'b10);
          neg_q    <= a_neg ^ b_neg;
          mcand_q  <= {{N{1'b0}}, a_mag};
          mplier_q <= b_mag;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        BUSY: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_step) MulRes <= res_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 A  input  N  multiplicand, sampled only on accept.
REQ-005 B  input  N  multiplier, sampled only on accept.
REQ-006 ALUSel  input  4  op code: 4'b1000 mul, 4'b1001 mulh, 4'b1010 mulhsu, 4'b1011 mulhu.
REQ-007 in_valid  input  1  upstream operands/op valid.
REQ-008 in_ready  output  1  unit can accept; high only in IDLE.
REQ-009 out_valid  output  1  MulRes valid; high only in DONE.
REQ-010 out_ready  input  1  downstream consumes result.
REQ-011 MulRes  output  N  registered result.

Function
REQ-012 States SHALL be IDLE, BUSY, DONE; accept = in_valid & in_ready at a rising edge.
REQ-013 IDLE: on accept, register op, |A|/|B| magnitudes per op signedness, result-negate flag, clear 2N-bit accumulator, counter=0, go to BUSY; else stay.
REQ-014 Signedness: mul and mulh treat A,B signed; mulhsu A signed, B unsigned; mulhu both unsigned; negate flag = XOR of signs of signed-treated operands.
REQ-015 BUSY: one shift-add step per cycle (LSB of multiplier magnitude selects add of shifted multiplicand); counter increments; after step N-1 go to DONE.
REQ-016 On BUSY->DONE, 2N-bit product SHALL be conditionally two's-complement negated and MulRes loaded: low N bits for mul, high N bits for mulh/mulhsu/mulhu.
REQ-017 Latency (macro off): out_valid SHALL rise exactly N clock edges after the accepting edge.
REQ-018 Any ALUSel other than the four mul codes SHALL complete with normal latency and MulRes = 0.
REQ-019 DONE: MulRes and out_valid held stable until out_valid & out_ready; then go to IDLE, out_valid=0 next cycle; no accept in the same edge.
REQ-020 Changes on A, B, ALUSel, in_valid during BUSY/DONE SHALL be ignored.
REQ-021 Arithmetic exact for all inputs incl. magnitude 2^(N-1) (most negative value); product mod 2^(2N).

Reset
REQ-022 While rst high: state=IDLE, in_ready=1, out_valid=0, MulRes=0, accumulator/counter/flags=0.
REQ-023 rst asserted mid-BUSY or in DONE SHALL abort the operation; no result delivered after release.
REQ-024 First accept possible on first rising edge after rst deasserts.

Configuration
REQ-025 Macro MUL_EARLY_OUT_EN: when defined, BUSY SHALL exit to DONE after the first step at which the remaining multiplier magnitude is zero (minimum 1 BUSY cycle, maximum N); results bit-identical to macro-off.
REQ-026 Without MUL_EARLY_OUT_EN, BUSY lasts exactly N cycles for every operand.

Verification
REQ-027 mul A=0xFFFFFFFF, B=2 -> MulRes=0xFFFFFFFE, out_valid exactly 32 edges after accept (macro off).
REQ-028 mulh A=0x80000000, B=0x80000000 -> 0x40000000; mulh A=0xFFFFFFFF, B=0xFFFFFFFF -> 0x00000000.
REQ-029 mulhu A=B=0xFFFFFFFF -> 0xFFFFFFFE; mulhsu A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 Hold out_ready=0 10 cycles in DONE, toggle A/B -> MulRes/out_valid stable, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-031 Assert rst at BUSY cycle 5 -> out_valid=0, MulRes=0, in_ready=1 immediately; no stale result later.
REQ-032 MUL_EARLY_OUT_EN: mul A=7, B=3 -> 0x00000015 with out_valid 2 edges after accept; random 10k vectors match macro-off results.
